// File: rtl/serial_subtractor_if.sv
// ============================================================================
// serial_subtractor_if : start/busy/done handshake and operand/result bus
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial a - b - borrow_in, LSB first, one borrow flop
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] result_q, result_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             x_bit, y_bit, d_bit, brw_next;
  logic [WIDTH-1:0] shifted;

  // One full-subtractor cell; the new bit enters at the MSB of the partial result.
  always_comb begin
    x_bit    = a_sh_q[0];
    y_bit    = b_sh_q[0];
    d_bit    = x_bit ^ y_bit ^ brw_q;
    brw_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
    shifted  = {d_bit, result_q};
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    result_d     = result_q;
    diff_d       = diff_q;
    brw_d        = brw_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = BUSY;
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.borrow_in;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        brw_d    = brw_next;
        result_d = shifted[WIDTH-1:1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          diff_d       = shifted;
          borrow_out_d = brw_next;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      result_q     <= '0;
      diff_q       <= '0;
      brw_q        <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      result_q     <= result_d;
      diff_q       <= diff_d;
      brw_q        <= brw_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.busy       = (state_q == BUSY);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed table, corner sequences and random ops
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[8];

  // Reference: plain unsigned arithmetic, top bit of the W+1-bit result is the borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Runs one operation and checks the handshake timing along the way.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       output logic [W-1:0] rd, output logic rb);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.a         = ta;
    bus.b         = tb_v;
    bus.borrow_in = tbin;
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < W + 6 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        lat++;
        if (bus.busy) busy_cnt++;
      end
    end
    if (!seen) lat = 999;
    check("latency", 64'(lat), 64'(W));
    check("busy_cycles", 64'(busy_cnt), 64'(W));
    rd = bus.diff;
    rb = bus.borrow_out;
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  // Waits for done with a bound; reports a timeout as a failed check.
  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * W && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    logic [W:0]   m;
    logic [W-1:0] ra, rbv;
    logic         rc;
    bit           ok;
    bit           spurious;
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    logic         ops_c[3];
    int           n_done;
    int           last_cyc;
    int           cyc;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{8'd5,   8'd3,   1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'd3,   8'd5,   1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00,  8'h00,  1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF,  8'h00,  1'b1, 8'hFE, 1'b0};
    vecs[5] = '{8'h00,  8'hFF,  1'b0, 8'h01, 1'b1};
    vecs[6] = '{8'h80,  8'h01,  1'b0, 8'h7F, 1'b0};
    vecs[7] = '{8'h10,  8'h0F,  1'b1, 8'h00, 1'b0};

    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_diff", 64'(bus.diff), 64'd0);
    check("reset_bout", 64'(bus.borrow_out), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rb);
      check($sformatf("vec%0d_diff", i), 64'(rd), 64'(vecs[i].exp_diff));
      check($sformatf("vec%0d_bout", i), 64'(rb), 64'(vecs[i].exp_bout));
    end

    // start and operand changes during BUSY must be ignored.
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h13; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.a = 8'h01; bus.b = 8'hEE; bus.borrow_in = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("ignore_start", ok);
    check("ignore_start_diff", 64'(bus.diff), 64'h47);
    check("ignore_start_bout", 64'(bus.borrow_out), 64'd0);
    repeat (W + 3) @(negedge clk);
    check("ignore_start_no_second_op", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.a = 8'h33; bus.b = 8'h44; bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_diff", 64'(bus.diff), 64'd0);
    check("midreset_bout", 64'(bus.borrow_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.done || bus.busy) spurious = 1'b1;
    end
    check("no_done_after_abort", 64'(spurious), 64'd0);
    do_op(8'h20, 8'h21, 1'b1, rd, rb);
    check("post_reset_diff", 64'(rd), 64'hFE);
    check("post_reset_bout", 64'(rb), 64'd1);

    // start held high over three operations.
    ops_a[0] = 8'h90; ops_b[0] = 8'h10; ops_c[0] = 1'b1;
    ops_a[1] = 8'h02; ops_b[1] = 8'h04; ops_c[1] = 1'b0;
    ops_a[2] = 8'hC3; ops_b[2] = 8'h3C; ops_c[2] = 1'b1;
    @(negedge clk);
    bus.a = ops_a[0]; bus.b = ops_b[0]; bus.borrow_in = ops_c[0]; bus.start = 1'b1;
    n_done   = 0;
    last_cyc = 0;
    cyc      = 0;
    while (n_done < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.busy && n_done > 0 && cyc == last_cyc + 4) begin
        m = model(ops_a[n_done-1], ops_b[n_done-1], ops_c[n_done-1]);
        check($sformatf("held_diff_op%0d", n_done - 1), 64'(bus.diff), 64'(m[W-1:0]));
      end
      if (bus.done) begin
        m = model(ops_a[n_done], ops_b[n_done], ops_c[n_done]);
        check($sformatf("b2b_diff_op%0d", n_done), 64'(bus.diff), 64'(m[W-1:0]));
        check($sformatf("b2b_bout_op%0d", n_done), 64'(bus.borrow_out), 64'(m[W]));
        if (n_done > 0)
          check($sformatf("b2b_spacing_op%0d", n_done), 64'(cyc - last_cyc), 64'(W + 2));
        last_cyc = cyc;
        n_done++;
        if (n_done < 3) begin
          bus.a = ops_a[n_done]; bus.b = ops_b[n_done]; bus.borrow_in = ops_c[n_done];
        end
      end
    end
    if (n_done < 3) check("b2b_timeout", 64'(n_done), 64'd3);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rbv = W'($urandom);
      rc  = 1'($urandom);
      do_op(ra, rbv, rc, rd, rb);
      m = model(ra, rbv, rc);
      check($sformatf("rand%0d", i), 64'({rb, rd}), 64'(m));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
